// File: rtl/rptr_stream_rd_pkg.sv
// Shared constants and types for the read-side stream port of the async FIFO.
package rptr_stream_rd_pkg;

  localparam int DEF_ADDRSIZE = 4;
  localparam int DEF_DSIZE    = 8;
  localparam int DEF_AE_LEVEL = 2;

  // Output buffer occupancy, 0..2 entries.
  typedef logic [1:0] occ_t;
  localparam occ_t OCC_DEPTH = 2'd2;

endpackage

// File: rtl/rptr_stream_rd_gray2bin.sv
// Combinational gray-to-binary conversion: each binary bit is the xor of all gray bits at or above it.
module rptr_stream_rd_gray2bin #(
  parameter int N = 5
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^gray[N-1:i];
  end

endmodule

// File: rtl/rptr_stream_rd.sv
// Read-domain port of the async FIFO: owns the read pointer and empty flag, and
// prefetches memory words into a 2-entry buffer presented as a valid/ready stream.
module rptr_stream_rd
  import rptr_stream_rd_pkg::*;
#(
  parameter int ADDRSIZE = DEF_ADDRSIZE,
  parameter int DSIZE    = DEF_DSIZE,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DSIZE-1:0]    rdata,
  output logic [DSIZE-1:0]    m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

  logic [PW-1:0]    rbin, rbinnext, rgraynext, wbin, level_next;
  occ_t             ocnt, cnt_after, ocnt_next;
  logic             head, head_next, wr_idx;
  logic             take, pop;
  logic [DSIZE-1:0] obuf [2];

  rptr_stream_rd_gray2bin #(.N(PW)) u_wbin (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  // Prefetch whenever the buffer will have a free slot after this cycle's take,
  // so a full buffer drained at one word per cycle is refilled in the same edge.
  always_comb begin
    take       = m_valid & m_ready;
    cnt_after  = ocnt - occ_t'(take);
    pop        = ~rempty & (cnt_after < OCC_DEPTH);
    rbinnext   = rbin + PW'(pop);
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
    head_next  = head ^ take;
    wr_idx     = head_next ^ cnt_after[0];
    ocnt_next  = cnt_after + occ_t'(pop);
    level_next = wbin - rbinnext;
  end

  assign raddr  = rbin[ADDRSIZE-1:0];
  assign m_data = obuf[head];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ocnt          <= '0;
      head          <= 1'b0;
      m_valid       <= 1'b0;
      obuf[0]       <= '0;
      obuf[1]       <= '0;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == rq2_wptr);
      ocnt          <= ocnt_next;
      head          <= head_next;
      m_valid       <= (ocnt_next != '0);
      if (pop) obuf[wr_idx] <= rdata;
      // Level lags the writer through the synchroniser, so it only ever under-reports.
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= AE_THRESH);
    end
  end

endmodule

// File: tb/tb_rptr_stream_rd.sv
// Self-checking bench for rptr_stream_rd: directed vector table plus hand-written
// wrap, almost-empty, reset and randomised scoreboard sequences.
module tb_rptr_stream_rd;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [4:0] rq2_wptr;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic [7:0] rdata;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       rempty;
  logic [4:0] rlevel;
  logic       ralmost_empty;

  logic [7:0] mem [16];
  logic [4:0] wbin;
  logic [7:0] exp_q [$];
  int total = 0;
  int bad = 0;

  assign rdata = mem[raddr];

  always #5 rclk = ~rclk;

  rptr_stream_rd #(.ADDRSIZE(4), .DSIZE(8), .AE_LEVEL(2)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rq2_wptr      (rq2_wptr),
    .rptr          (rptr),
    .raddr         (raddr),
    .rdata         (rdata),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .rempty        (rempty),
    .rlevel        (rlevel),
    .ralmost_empty (ralmost_empty)
  );

  typedef struct {
    int         nwr;
    logic [7:0] dval;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_rempty;
    logic [4:0] exp_rlevel;
    logic       exp_ae;
    logic [3:0] exp_raddr;
    logic [4:0] exp_rptr;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [4:0] toGray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic writeWord(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 5'd1;
    rq2_wptr = toGray(wbin);
  endtask

  // One rclk of streaming: scoreboard any take, optionally write, then check stall hold and no pop while empty.
  task automatic runCycle(input logic rdy, input logic wr, input logic [7:0] d);
    logic       was_stall, was_empty;
    logic [7:0] held;
    logic [4:0] old_rptr;
    m_ready = rdy;
    if (m_valid && rdy) begin
      if (exp_q.size() == 0) checkOutput("take_underflow", 32'(m_data), 32'hFFFF_FFFF);
      else checkOutput("take_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
    if (wr) writeWord(d);
    was_stall = m_valid && !rdy;
    held      = m_data;
    was_empty = rempty;
    old_rptr  = rptr;
    step();
    if (was_stall) begin
      checkOutput("stall_valid", 32'(m_valid), 32'd1);
      checkOutput("stall_data", 32'(m_data), 32'(held));
    end
    if (was_empty) checkOutput("no_pop_when_empty", 32'(rptr), 32'(old_rptr));
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int k = 0; k < v.nwr; k++) writeWord(v.dval + 8'(k));
    m_ready = v.rdy;
    step();
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d_valid", idx), 32'(m_valid), 32'(v.exp_valid));
    if (v.exp_valid) checkOutput($sformatf("v%0d_data", idx), 32'(m_data), 32'(v.exp_data));
    checkOutput($sformatf("v%0d_rempty", idx), 32'(rempty), 32'(v.exp_rempty));
    checkOutput($sformatf("v%0d_rlevel", idx), 32'(rlevel), 32'(v.exp_rlevel));
    checkOutput($sformatf("v%0d_ae", idx), 32'(ralmost_empty), 32'(v.exp_ae));
    checkOutput($sformatf("v%0d_raddr", idx), 32'(raddr), 32'(v.exp_raddr));
    checkOutput($sformatf("v%0d_rptr", idx), 32'(rptr), 32'(v.exp_rptr));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rptr"}, 32'(rptr), 32'd0);
    checkOutput({tag, "_raddr"}, 32'(raddr), 32'd0);
    checkOutput({tag, "_rempty"}, 32'(rempty), 32'd1);
    checkOutput({tag, "_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(m_data), 32'd0);
    checkOutput({tag, "_rlevel"}, 32'(rlevel), 32'd0);
    checkOutput({tag, "_ae"}, 32'(ralmost_empty), 32'd1);
  endtask

  logic [4:0] prev_bin;
  int         sent, taken0, bubbles, waited;
  bit         primed, saw_11000, saw_00000, ae_seen;

  initial begin
    // nwr dval rdy | valid data rempty rlevel ae raddr rptr
    vecs[0]  = '{1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 4'd0, 5'b00000};
    vecs[1]  = '{0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 5'd0, 1'b1, 4'd1, 5'b00001};
    vecs[2]  = '{0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 4'd1, 5'b00001};
    vecs[3]  = '{5, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 5'd5, 1'b0, 4'd1, 5'b00001};
    vecs[4]  = '{0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 5'd4, 1'b0, 4'd2, 5'b00011};
    vecs[5]  = '{0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 5'd3, 1'b0, 4'd3, 5'b00010};
    vecs[6]  = '{0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 5'd3, 1'b0, 4'd3, 5'b00010};
    vecs[7]  = '{0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0, 5'd2, 1'b1, 4'd4, 5'b00110};
    vecs[8]  = '{0, 8'h00, 1'b1, 1'b1, 8'h13, 1'b0, 5'd1, 1'b1, 4'd5, 5'b00111};
    vecs[9]  = '{0, 8'h00, 1'b1, 1'b1, 8'h14, 1'b1, 5'd0, 1'b1, 4'd6, 5'b00101};
    vecs[10] = '{0, 8'h00, 1'b1, 1'b1, 8'h15, 1'b1, 5'd0, 1'b1, 4'd6, 5'b00101};
    vecs[11] = '{0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 4'd6, 5'b00101};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    wbin     = 5'd0;
    rq2_wptr = 5'd0;
    m_ready  = 1'b0;
    rrst_n   = 1'b1;
    #3 rrst_n = 1'b0;
    step();
    step();
    checkResetState("por");
    #3 rrst_n = 1'b1;
    step();
    checkResetState("por_release");

    // Tests 2 and 3: first-word latency, stall with two prefetched words, ordered drain.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end
    exp_q.delete();

    // Test 4: 40 words back to back across the memory and pointer-MSB wrap.
    prev_bin  = 5'd6;
    sent      = 0;
    bubbles   = 0;
    primed    = 1'b0;
    saw_11000 = 1'b0;
    saw_00000 = 1'b0;
    for (int c = 0; c < 200 && (sent < 40 || exp_q.size() != 0); c++) begin
      runCycle(1'b1, sent < 40, 8'h80 + 8'(sent));
      if (sent < 40) sent++;
      if (rptr != toGray(prev_bin)) begin
        checkOutput("t4_rptr_step", 32'(rptr), 32'(toGray(prev_bin + 5'd1)));
        prev_bin = prev_bin + 5'd1;
      end
      checkOutput("t4_raddr", 32'(raddr), 32'(prev_bin[3:0]));
      if (rptr == 5'b11000) saw_11000 = 1'b1;
      if (primed && rptr == 5'b00000) saw_00000 = 1'b1;
      if (m_valid) primed = 1'b1;
      else if (primed && (exp_q.size() != 0)) bubbles++;
    end
    checkOutput("t4_all_delivered", 32'(exp_q.size()), 32'd0);
    checkOutput("t4_bubbles", 32'(bubbles), 32'd0);
    checkOutput("t4_saw_11000", 32'(saw_11000), 32'd1);
    checkOutput("t4_saw_00000", 32'(saw_00000), 32'd1);
    checkOutput("t4_final_rptr", 32'(rptr), 32'(toGray(5'd46)));

    // Test 1: reset asserted mid-cycle while the stream holds valid data.
    writeWord(8'h31);
    writeWord(8'h32);
    writeWord(8'h33);
    m_ready = 1'b0;
    waited = 0;
    while (!m_valid && waited < 10) begin
      step();
      waited++;
    end
    checkOutput("t1_valid_before_reset", 32'(m_valid), 32'd1);
    #2 rrst_n = 1'b0;
    #1;
    checkResetState("t1_async");
    exp_q.delete();
    wbin     = 5'd0;
    rq2_wptr = 5'd0;
    step();
    #3 rrst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checkOutput("t1_no_valid_after_release", 32'(m_valid), 32'd0);
    end

    // Test 5: a full memory from empty, then drain through the almost-empty threshold.
    for (int i = 0; i < 16; i++) writeWord(8'h60 + 8'(i));
    checkOutput("t5_wptr_gray16", 32'(rq2_wptr), 32'b11000);
    m_ready = 1'b0;
    step();
    checkOutput("t5_level16", 32'(rlevel), 32'd16);
    checkOutput("t5_ae0", 32'(ralmost_empty), 32'd0);
    checkOutput("t5_rempty0", 32'(rempty), 32'd0);
    step();
    checkOutput("t5_level15", 32'(rlevel), 32'd15);
    step();
    checkOutput("t5_level14", 32'(rlevel), 32'd14);
    checkOutput("t5_head", 32'(m_data), 32'h60);
    step();
    checkOutput("t5_level14_settled", 32'(rlevel), 32'd14);
    checkOutput("t5_valid", 32'(m_valid), 32'd1);
    ae_seen = 1'b0;
    for (int c = 0; c < 60 && (exp_q.size() != 0 || m_valid); c++) begin
      runCycle(1'b1, 1'b0, 8'h00);
      if (!ae_seen && ralmost_empty) begin
        ae_seen = 1'b1;
        checkOutput("t5_ae_at_level2", 32'(rlevel), 32'd2);
      end
    end
    checkOutput("t5_ae_seen", 32'(ae_seen), 32'd1);
    checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);

    // Test 6: random back-pressure and write bursts against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      runCycle(1'($urandom_range(0, 1)),
               (exp_q.size() < 16) && ($urandom_range(0, 2) != 0),
               8'($urandom));
    end
    for (int c = 0; c < 200 && (exp_q.size() != 0 || m_valid); c++) runCycle(1'b1, 1'b0, 8'h00);
    checkOutput("t6_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("t6_idle_valid", 32'(m_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
